// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer: in-order FIFO of dirty-line writebacks and uncached
// stores feeding the AXI bridge write port, with line-granular RAW detection.
module dcache_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wb_req,
  input  logic         wb_type,
  input  logic [31:0]  wb_addr,
  input  logic [2:0]   wb_size,
  input  logic [3:0]   wb_wstrb,
  input  logic [127:0] wb_data,
  output logic         wb_rdy,
  input  logic [31:0]  chk_addr,
  output logic         chk_hit,
  output logic         wb_empty,
  output logic         data_wr_req,
  output logic         data_wr_type,
  output logic [31:0]  data_wr_addr,
  output logic [2:0]   data_wr_size,
  output logic [3:0]   data_wr_wstrb,
  output logic [127:0] data_wr_data,
  input  logic         data_wr_rdy,
  input  logic         data_wr_ok
);

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    REQ     = 3'b010,
    WAIT_OK = 3'b100
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t           state;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic [DEPTH-1:0] valid;

  logic             e_type  [DEPTH];
  logic [31:0]      e_addr  [DEPTH];
  logic [2:0]       e_size  [DEPTH];
  logic [3:0]       e_wstrb [DEPTH];
  logic [127:0]     e_data  [DEPTH];

  logic push;
  logic pop;

  assign wb_rdy   = (count != FULL);
  assign push     = wb_req & wb_rdy;
  assign pop      = (state == WAIT_OK) & data_wr_ok;
  assign wb_empty = (count == '0) & (state == IDLE);

  // Head entry is presented directly; it cannot change until it is popped.
  assign data_wr_type  = e_type[rptr];
  assign data_wr_addr  = e_addr[rptr];
  assign data_wr_size  = e_size[rptr];
  assign data_wr_wstrb = e_wstrb[rptr];
  assign data_wr_data  = e_data[rptr];

  // Entry payload storage, written only at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      e_type[wptr]  <= wb_type;
      e_addr[wptr]  <= wb_addr;
      e_size[wptr]  <= wb_size;
      e_wstrb[wptr] <= wb_wstrb;
      e_data[wptr]  <= wb_data;
    end
  end

  // Pointers, occupancy and valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (push) begin
        valid[wptr] <= 1'b1;
        wptr        <= wptr + AW'(1);
      end
      if (pop) begin
        valid[rptr] <= 1'b0;
        rptr        <= rptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Drain FSM: one outstanding bridge write, request output registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      data_wr_req <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (count != '0) begin
            state       <= REQ;
            data_wr_req <= 1'b1;
          end
        end
        REQ: begin
          if (data_wr_rdy) begin
            state       <= WAIT_OK;
            data_wr_req <= 1'b0;
          end
        end
        WAIT_OK: begin
          if (data_wr_ok) state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          data_wr_req <= 1'b0;
        end
      endcase
    end
  end

  // Line-granular hazard match against every registered valid entry.
  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (e_addr[i][31:4] == chk_addr[31:4])) chk_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb_dcache_write_buffer: directed scenarios plus randomized traffic,
// checked against a queue-based model of the write buffer.
module tb_dcache_write_buffer;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         wb_req;
  logic         wb_type;
  logic [31:0]  wb_addr;
  logic [2:0]   wb_size;
  logic [3:0]   wb_wstrb;
  logic [127:0] wb_data;
  logic         wb_rdy;
  logic [31:0]  chk_addr;
  logic         chk_hit;
  logic         wb_empty;
  logic         data_wr_req;
  logic         data_wr_type;
  logic [31:0]  data_wr_addr;
  logic [2:0]   data_wr_size;
  logic [3:0]   data_wr_wstrb;
  logic [127:0] data_wr_data;
  logic         data_wr_rdy;
  logic         data_wr_ok;

  dcache_write_buffer #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk(clk), .reset(reset),
    .wb_req(wb_req), .wb_type(wb_type), .wb_addr(wb_addr),
    .wb_size(wb_size), .wb_wstrb(wb_wstrb), .wb_data(wb_data),
    .wb_rdy(wb_rdy), .chk_addr(chk_addr), .chk_hit(chk_hit),
    .wb_empty(wb_empty), .data_wr_req(data_wr_req),
    .data_wr_type(data_wr_type), .data_wr_addr(data_wr_addr),
    .data_wr_size(data_wr_size), .data_wr_wstrb(data_wr_wstrb),
    .data_wr_data(data_wr_data), .data_wr_rdy(data_wr_rdy),
    .data_wr_ok(data_wr_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         t;
    logic [31:0]  a;
    logic [2:0]   s;
    logic [3:0]   w;
    logic [127:0] d;
  } ent_t;

  ent_t mq[$];
  bit   inflight;
  bit   just_done;
  int   lag;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: compare outputs with the model, then advance it.
  always @(negedge clk) begin
    logic exp_hit;
    bit   was_full;
    exp_hit = 1'b0;
    foreach (mq[i]) if (mq[i].a[31:4] == chk_addr[31:4]) exp_hit = 1'b1;
    chk("wb_rdy", wb_rdy, mq.size() != DEPTH);
    chk("wb_empty", wb_empty, mq.size() == 0);
    chk("chk_hit", chk_hit, exp_hit);
    chk("req_legal", data_wr_req && (inflight || mq.size() == 0), 0);
    if (just_done) chk("drain_gap", data_wr_req, 0);
    if (data_wr_req && !inflight && mq.size() > 0) begin
      chk("wr_type", data_wr_type, mq[0].t);
      chk("wr_addr", data_wr_addr, mq[0].a);
      chk("wr_size", data_wr_size, mq[0].s);
      chk("wr_wstrb", data_wr_wstrb, mq[0].w);
      chk("wr_data", data_wr_data, mq[0].d);
    end
    if (mq.size() > 0 && !inflight && !data_wr_req) lag++;
    else lag = 0;
    chk("drain_lag", lag > 1, 0);
    just_done = 0;
    if (reset) begin
      mq.delete();
      inflight = 0;
      lag = 0;
    end else begin
      was_full = (mq.size() == DEPTH);
      if (inflight && data_wr_ok) begin
        void'(mq.pop_front());
        inflight = 0;
        just_done = 1;
      end else if (data_wr_req && data_wr_rdy && !inflight) begin
        inflight = 1;
      end
      if (wb_req && !was_full)
        mq.push_back('{wb_type, wb_addr, wb_size, wb_wstrb, wb_data});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic t, input logic [31:0] a,
                      input logic [2:0] s, input logic [3:0] w,
                      input logic [127:0] d);
    wb_type = t; wb_addr = a; wb_size = s; wb_wstrb = w; wb_data = d;
    wb_req = 1'b1;
    step();
    wb_req = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_req();
    int n = 0;
    @(negedge clk);
    while (!data_wr_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_timeout", n < 20, 1);
  endtask

  task automatic issue();
    wait_req();
    @(posedge clk);
    #1 data_wr_rdy = 1'b1;
    step();
    data_wr_rdy = 1'b0;
  endtask

  task automatic drain_one(input int dly);
    issue();
    repeat (dly) step();
    data_wr_ok = 1'b1;
    step();
    data_wr_ok = 1'b0;
  endtask

  initial begin
    int lat;
    bit out;
    int dly;
    reset = 1'b1; wb_req = 0; wb_type = 0; wb_addr = 0; wb_size = 0;
    wb_wstrb = 0; wb_data = 0; chk_addr = 0; data_wr_rdy = 0;
    data_wr_ok = 0; inflight = 0; just_done = 0; lag = 0;
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rdy", wb_rdy, 1);
    chk("rst_req", data_wr_req, 0);
    chk("rst_empty", wb_empty, 1);
    chk("rst_hit", chk_hit, 0);

    // 1: single line writeback, latency and completion
    step();
    push(1'b1, 32'h1fc0_0100, 3'd4, 4'hf, rnd128());
    lat = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (data_wr_req) begin
        lat = k;
        break;
      end
    end
    chk("t1_req_latency", lat, 2);
    chk("t1_addr", data_wr_addr, 32'h1fc0_0100);
    repeat (3) step();
    data_wr_rdy = 1'b1;
    step();
    data_wr_rdy = 1'b0;
    step();
    data_wr_ok = 1'b1;
    step();
    data_wr_ok = 1'b0;
    @(negedge clk);
    chk("t1_empty", wb_empty, 1);

    // 2: fill with bridge stalled, 5th held, then in-order drain with wrap
    step();
    for (int i = 0; i < 4; i++)
      push(1'b1, 32'h0000_4000 + 32'(i * 16), 3'd4, 4'hf, rnd128());
    @(negedge clk);
    chk("t2_full_rdy", wb_rdy, 0);
    wb_type = 0; wb_addr = 32'h0000_5000; wb_data = rnd128();
    wb_req = 1'b1;
    repeat (3) step();
    chk("t2_held_rdy", wb_rdy, 0);
    wb_req = 1'b0;
    for (int i = 0; i < 4; i++) drain_one(i);
    @(negedge clk);
    chk("t2_drained", wb_empty, 1);

    // 3: ok and wb_req together at full
    step();
    for (int i = 0; i < 4; i++)
      push(1'b0, 32'h0000_6000 + 32'(i * 16), 3'd2, 4'hf, rnd128());
    issue();
    step();
    wb_type = 1; wb_addr = 32'h0000_7000; wb_data = rnd128();
    wb_req = 1'b1;
    data_wr_ok = 1'b1;
    step();
    data_wr_ok = 1'b0;
    @(negedge clk);
    chk("t3_rdy_after_pop", wb_rdy, 1);
    step();
    wb_req = 1'b0;
    @(negedge clk);
    chk("t3_full_again", wb_rdy, 0);
    for (int i = 0; i < 4; i++) drain_one(1);

    // 4: hazard on an in-flight line
    step();
    push(1'b1, 32'h0000_2000, 3'd4, 4'hf, rnd128());
    issue();
    chk_addr = 32'h0000_2010;
    @(negedge clk);
    chk("t4_other_line", chk_hit, 0);
    step();
    chk_addr = 32'h0000_2008;
    @(negedge clk);
    chk("t4_hit_wait", chk_hit, 1);
    step();
    data_wr_ok = 1'b1;
    @(negedge clk);
    chk("t4_hit_ok_cycle", chk_hit, 1);
    step();
    data_wr_ok = 1'b0;
    @(negedge clk);
    chk("t4_hit_after", chk_hit, 0);

    // 5: uncached store, spurious ok in IDLE and REQ
    step();
    data_wr_ok = 1'b1;
    step();
    data_wr_ok = 1'b0;
    @(negedge clk);
    chk("t5_spur_idle_empty", wb_empty, 1);
    step();
    push(1'b0, 32'hbfaf_f002, 3'd0, 4'b0100, {96'h0, 32'h00ab_0000});
    wait_req();
    chk("t5_wstrb", data_wr_wstrb, 4'b0100);
    step();
    data_wr_ok = 1'b1;
    step();
    data_wr_ok = 1'b0;
    @(negedge clk);
    chk("t5_spur_req_held", data_wr_req, 1);
    drain_one(0);

    // 6: reset during WAIT_OK with 3 entries
    step();
    for (int i = 0; i < 3; i++)
      push(1'b1, 32'h0000_8000 + 32'(i * 16), 3'd4, 4'hf, rnd128());
    issue();
    chk_addr = 32'h0000_8010;
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_req", data_wr_req, 0);
    chk("t6_empty", wb_empty, 1);
    chk("t6_hit", chk_hit, 0);
    chk("t6_rdy", wb_rdy, 1);

    // Randomized traffic with a randomly stalling bridge
    step();
    out = 0;
    dly = 0;
    fork
      begin
        for (int c = 0; c < 1500; c++) begin
          wb_req   = ($urandom_range(0, 2) == 0);
          wb_type  = 1'($urandom_range(0, 1));
          wb_addr  = {16'h1000, 8'h0, 4'($urandom_range(0, 7)),
                      4'($urandom_range(0, 15))};
          wb_size  = 3'($urandom_range(0, 4));
          wb_wstrb = 4'($urandom);
          wb_data  = rnd128();
          chk_addr = {16'h1000, 8'h0, 4'($urandom_range(0, 7)),
                      4'($urandom_range(0, 15))};
          step();
        end
        wb_req = 1'b0;
      end
      begin
        for (int c = 0; c < 1700; c++) begin
          bit iss;
          @(negedge clk);
          iss = data_wr_req & data_wr_rdy;
          @(posedge clk);
          #1;
          if (iss) begin
            out = 1;
            dly = $urandom_range(0, 4);
          end
          data_wr_ok = 1'b0;
          if (out) begin
            if (dly == 0) begin
              data_wr_ok = 1'b1;
              out = 0;
            end else begin
              dly--;
            end
          end else if ($urandom_range(0, 15) == 0) begin
            data_wr_ok = 1'b1;
          end
          data_wr_rdy = 1'($urandom_range(0, 1));
        end
        data_wr_ok = 1'b0;
        data_wr_rdy = 1'b0;
      end
    join
    @(negedge clk);
    chk("final_empty", wb_empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
